// File: rtl/saturn_debug_uart_tx.sv
// saturn_debug_uart_tx
// Buffers debug characters from the bus controller in a small FIFO and shifts
// them out as 8N1 asynchronous serial, LSB first. Timing runs on the raw clock,
// so output keeps draining while the CPU core is halted.
// FIFO_LOG2 must be at least 1 and CLKS_PER_BIT at least 2.
module saturn_debug_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_LOG2    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_char_valid,
    input  logic [7:0]           i_char,
    output logic                 o_char_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic [FIFO_LOG2:0]   o_fifo_count,
    output logic                 o_overflow
);

    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam int TW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [TW-1:0]        TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]        TIMER_ONE = TW'(1);
    localparam logic [FIFO_LOG2:0]   CNT_ONE   = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2:0]   CNT_FULL  = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE   = FIFO_LOG2'(1);
    localparam logic [2:0]           BIT_ONE   = 3'd1;
    localparam logic [2:0]           BIT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]     count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             mem_q [DEPTH];

    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   bit_end;

    // Ready is taken from the registered count only, so a same-cycle pop never
    // lets a full FIFO accept a push.
    assign o_char_ready = (count_q != CNT_FULL);
    assign fifo_empty   = (count_q == '0);
    assign push         = i_char_valid && o_char_ready;
    assign bit_end      = (timer_q == TIMER_MAX);

    assign o_tx         = tx_q;
    assign o_fifo_count = count_q;
    assign o_overflow   = overflow_q;

    // Character storage; contents need no reset since the count gates reads.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_char;
        end
    end

    // State register for the FSM, bit timing, FIFO bookkeeping and the TX pin.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic: frame sequencing, bit timer, shifter and FIFO pops.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                bit_d   = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_ONE;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                bit_d   = '0;
            end
        endcase
    end

    // FIFO pointer, occupancy and sticky overflow updates.
    always_comb begin
        wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
        overflow_d = overflow_q || (i_char_valid && !o_char_ready);
    end

    // Output decode: the TX level follows the upcoming state so the pin register
    // changes on the same edge as the state, and busy covers frame plus backlog.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        o_busy = (state_q != IDLE) || !fifo_empty;
    end

endmodule

// File: tb/tb_saturn_debug_uart_tx.sv
// tb_saturn_debug_uart_tx
// Directed bench for the debug UART transmitter, run with 4 clocks per bit and
// a 4-entry FIFO so frames are short and the full condition is easy to reach.
module tb_saturn_debug_uart_tx;

    localparam int CPB  = 4;
    localparam int FLOG = 2;

    logic            clk = 1'b0;
    logic            rstN;
    logic            charValid;
    logic [7:0]      charIn;
    logic            charReady;
    logic            tx;
    logic            busy;
    logic [FLOG:0]   fifoCount;
    logic            overflow;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    saturn_debug_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_LOG2    (FLOG)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rstN),
        .i_char_valid (charValid),
        .i_char       (charIn),
        .o_char_ready (charReady),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_fifo_count (fifoCount),
        .o_overflow   (overflow)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the push interface, then let one edge consume it.
    task automatic applyStimulus(input logic valid, input logic [7:0] ch);
        charValid = valid;
        charIn    = ch;
        tick();
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Everything that must hold while reset or idle with an empty FIFO.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " tx"},       32'(tx),        32'd1);
        checkOutput({tag, " busy"},     32'(busy),      32'd0);
        checkOutput({tag, " ready"},    32'(charReady), 32'd1);
        checkOutput({tag, " count"},    32'(fifoCount), 32'd0);
        checkOutput({tag, " overflow"}, 32'(overflow),  32'd0);
    endtask

    // Walk one frame starting just after its pop edge (sample kStart), checking
    // the serial level every cycle; optionally push a char on the final edge.
    task automatic checkFrame(input logic [7:0] ch, input int kStart,
                              input logic pushAtEnd, input logic [7:0] endChar);
        logic expBit;
        int   seg;
        for (int k = kStart; k < 10 * CPB; k++) begin
            seg = k / CPB;
            if (seg == 0)      expBit = 1'b0;
            else if (seg == 9) expBit = 1'b1;
            else               expBit = ch[seg - 1];
            checkOutput($sformatf("tx %02h k%0d", ch, k), 32'(tx), 32'(expBit));
            checkOutput($sformatf("busy %02h k%0d", ch, k), 32'(busy), 32'd1);
            if (k == 10 * CPB - 1 && pushAtEnd) begin
                charValid = 1'b1;
                charIn    = endChar;
            end
            tick();
        end
        charValid = 1'b0;
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [7:0] ch;

        rstN      = 1'b0;
        charValid = 1'b0;
        charIn    = 8'h00;
        tick();
        tick();
        checkIdle("in reset");
        rstN = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checkIdle($sformatf("idle c%0d", i));
        end

        $display("[TB] single character 41");
        applyStimulus(1'b1, 8'h41);
        checkOutput("single count after push", 32'(fifoCount), 32'd1);
        checkOutput("single tx before pop", 32'(tx), 32'd1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("single count after pop", 32'(fifoCount), 32'd0);
        checkFrame(8'h41, 0, 1'b0, 8'h00);
        checkOutput("single busy end", 32'(busy), 32'd0);
        checkOutput("single tx end", 32'(tx), 32'd1);

        $display("[TB] back-to-back 55 AA");
        applyStimulus(1'b1, 8'h55);
        checkOutput("b2b count first", 32'(fifoCount), 32'd1);
        applyStimulus(1'b1, 8'hAA);
        charValid = 1'b0;
        checkOutput("b2b count second", 32'(fifoCount), 32'd1);
        checkFrame(8'h55, 0, 1'b0, 8'h00);
        checkOutput("b2b count at second pop", 32'(fifoCount), 32'd0);
        checkFrame(8'hAA, 0, 1'b0, 8'h00);
        checkOutput("b2b busy end", 32'(busy), 32'd0);

        $display("[TB] overflow with 6 pushes");
        for (int i = 0; i < 5; i++) begin
            ch = 8'(8'h31 + i);
            applyStimulus(1'b1, ch);
        end
        checkOutput("ovf count full", 32'(fifoCount), 32'd4);
        checkOutput("ovf ready full", 32'(charReady), 32'd0);
        checkOutput("ovf flag before", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 8'h36);
        charValid = 1'b0;
        checkOutput("ovf flag set", 32'(overflow), 32'd1);
        checkOutput("ovf count kept", 32'(fifoCount), 32'd4);
        checkFrame(8'h31, 4, 1'b0, 8'h00);
        checkOutput("ovf count after pop", 32'(fifoCount), 32'd3);
        for (int i = 1; i < 5; i++) begin
            ch = 8'(8'h31 + i);
            checkFrame(ch, 0, 1'b0, 8'h00);
        end
        checkOutput("ovf busy end", 32'(busy), 32'd0);
        checkOutput("ovf tx end", 32'(tx), 32'd1);
        checkOutput("ovf flag sticky", 32'(overflow), 32'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'h5A);
        charValid = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        checkOutput("mid tx data bit3", 32'(tx), 32'd0);
        checkOutput("mid count", 32'(fifoCount), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkIdle("async reset");
        tick();
        rstN = 1'b1;
        tick();
        checkIdle("after reset");
        applyStimulus(1'b1, 8'h0F);
        applyStimulus(1'b0, 8'h00);
        checkFrame(8'h0F, 0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            checkIdle($sformatf("discarded c%0d", i));
            tick();
        end

        $display("[TB] push during pop at stop end");
        applyStimulus(1'b1, 8'h61);
        applyStimulus(1'b1, 8'h62);
        charValid = 1'b0;
        checkFrame(8'h61, 0, 1'b1, 8'h63);
        checkOutput("simul count", 32'(fifoCount), 32'd1);
        checkOutput("simul tx start", 32'(tx), 32'd0);
        checkFrame(8'h62, 0, 1'b0, 8'h00);
        checkFrame(8'h63, 0, 1'b0, 8'h00);
        checkOutput("simul busy end", 32'(busy), 32'd0);
        checkOutput("simul count end", 32'(fifoCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/saturn_debug_uart_tx.md
Name: saturn_debug_uart_tx

Overview:
Serial transmitter at the far end of the bus controller's debug character stream (o_char_to_send). It buffers debug characters in a small FIFO and shifts them out as 8N1 asynchronous serial, LSB first. It sits beside saturn_bus in the top level and drives the board's debug UART TX pin. Serial timing runs on the raw clock, independent of the CPU clock enable and halt, so debug output drains even while the core is halted.

Parameters:
CLKS_PER_BIT, 104, i_clk cycles per serial bit; legal values are 2 or more.
FIFO_LOG2, 4, log2 of the FIFO depth (depth = 2**FIFO_LOG2 entries of 8 bits).

Ports:
i_clk  input  1  system clock; all state changes on the rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_char_valid  input  1  a character is presented on i_char this cycle.
i_char  input  8  character to send (from the bus controller's o_char_to_send).
o_char_ready  output  1  FIFO not full; a push is accepted only when this is 1.
o_tx  output  1  serial line; idles high.
o_busy  output  1  a frame is in progress or the FIFO is non-empty.
o_fifo_count  output  FIFO_LOG2+1  number of buffered characters, excluding the one being shifted.
o_overflow  output  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - o_tx=1, FSM in IDLE, FIFO empty, o_fifo_count=0.
  - o_char_ready=1, o_busy=0, o_overflow=0, bit timer=0, bit index=0.
  - Reset mid-frame aborts the frame immediately: o_tx returns high and buffered characters are discarded.
- Push:
  - At an edge where i_char_valid=1 and o_char_ready=1, i_char is written at the write pointer and the count increments.
  - If i_char_valid=1 and the FIFO is full, the character is dropped and o_overflow is set. o_overflow clears only on reset.
  - o_char_ready is derived from the registered count; a pop in the same cycle does not make a full FIFO accept a push.
- Pointers wrap modulo the depth. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - o_tx=1.
    - If the FIFO is non-empty at an edge: pop the head into the shift register, clear the timer, go to START.
    - Latency: a char pushed at edge E into an empty idle FIFO pops at E+1. o_tx is low from E+1.
  - START:
    - o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - o_tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
    - After bit 7 completes, go to STOP.
  - STOP:
    - o_tx=1 for CLKS_PER_BIT cycles.
    - At the end: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1; a bit ends when the timer equals CLKS_PER_BIT-1.
  - Timer width is clog2(CLKS_PER_BIT).
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- o_tx is driven from a register (glitch-free).
- o_busy = (state != IDLE) or (count != 0).
- o_fifo_count decrements on the pop edge.
- i_char is ignored while i_char_valid=0.
- The debug source does not retry dropped characters; dropping on full and flagging o_overflow is the required behaviour.

Test Plan:
- Reset and idle: hold i_reset_n=0, then release, run 50 cycles with no push -> o_tx=1, o_busy=0, o_char_ready=1, o_fifo_count=0, o_overflow=0 throughout.
- Single char (CLKS_PER_BIT=4): push 8'h41 at edge E -> o_tx low from E+1 for 4 cycles. Then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high for 4 cycles. o_busy falls after 40 cycles.
- Back-to-back: push 8'h55 then 8'hAA on consecutive cycles -> two contiguous 40-cycle frames with no idle gap. o_fifo_count goes 1 then 0 at the second pop.
- Full/overflow (FIFO_LOG2=2): push 6 chars on consecutive cycles -> the first pops and 4 are buffered. o_char_ready=0 and the 6th is dropped, o_overflow=1. Serial output is chars 1-5 only.
- Reset mid-frame: assert i_reset_n=0 during DATA bit 3 -> o_tx=1 immediately (asynchronously), count=0. After release, a new push of 8'h0F transmits a correct complete frame.
- Simultaneous push/pop: at the STOP end with count=1, push a new char -> count stays 1, the next frame starts immediately, and character order is preserved.
